// File: rtl/way_age_tracker.sv
// Per-set valid/age tracking for a set-associative cache, with a multi-cycle flush.
// Outputs present the post-update state of lookup_set_i one cycle later.
module way_age_tracker #(
    parameter int unsigned N_WAYS   = 2,
    parameter int unsigned N_POW    = 4,
    parameter int unsigned N_SETS   = 4,
    parameter int unsigned SET_BITS = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     access_valid_i,
    input  logic                     access_fill_i,
    input  logic [SET_BITS-1:0]      access_set_i,
    input  logic [N_POW-1:0]         access_way_i,
    input  logic                     inval_valid_i,
    input  logic [SET_BITS-1:0]      inval_set_i,
    input  logic [N_POW-1:0]         inval_way_i,
    input  logic [SET_BITS-1:0]      lookup_set_i,
    input  logic                     flush_req_i,
    output logic [N_WAYS-1:0]        line_empty_o,
    output logic [N_WAYS*32-1:0]     line_age_o,
    output logic                     flush_busy_o,
    output logic                     flush_done_o,
    output logic                     protocol_err_o
);

    localparam int unsigned AGE_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [SET_BITS-1:0]    cnt_q, cnt_d;
    logic [N_WAYS-1:0]      valid_q [N_SETS];
    logic [N_WAYS-1:0]      valid_d [N_SETS];
    logic [AGE_W-1:0]       age_q   [N_SETS][N_WAYS];
    logic [AGE_W-1:0]       age_d   [N_SETS][N_WAYS];

    logic                   err_d;
    logic                   done_d;
    logic                   acc_in_range;
    logic                   inv_in_range;
    logic                   acc_way_valid;
    logic [N_WAYS-1:0]      empty_d;
    logic [N_WAYS*AGE_W-1:0] age_flat_d;

    logic [N_WAYS-1:0]      line_empty_q;
    logic [N_WAYS*AGE_W-1:0] line_age_q;
    logic                   flush_busy_q;
    logic                   flush_done_q;
    logic                   protocol_err_q;

    // Next-state for the FSM and the per-set storage; the invalidate is applied after the access so it wins.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        age_d         = age_q;
        err_d         = 1'b0;
        done_d        = 1'b0;
        acc_in_range  = (access_way_i < N_POW'(N_WAYS));
        inv_in_range  = (inval_way_i < N_POW'(N_WAYS));
        acc_way_valid = 1'b0;
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            if (N_POW'(w) == access_way_i) begin
                acc_way_valid = valid_q[access_set_i][w];
            end
        end

        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
                if (access_valid_i) begin
                    if (!acc_in_range || (!access_fill_i && !acc_way_valid)) begin
                        err_d = 1'b1;
                    end else begin
                        for (int unsigned w = 0; w < N_WAYS; w++) begin
                            if (N_POW'(w) == access_way_i) begin
                                valid_d[access_set_i][w] = 1'b1;
                                age_d[access_set_i][w]   = '0;
                            end else if (valid_q[access_set_i][w] &&
                                         (age_q[access_set_i][w] != '1)) begin
                                age_d[access_set_i][w] = age_q[access_set_i][w] + AGE_W'(1);
                            end
                        end
                    end
                end
                if (inval_valid_i) begin
                    if (!inv_in_range) begin
                        err_d = 1'b1;
                    end else begin
                        for (int unsigned w = 0; w < N_WAYS; w++) begin
                            if (N_POW'(w) == inval_way_i) begin
                                valid_d[inval_set_i][w] = 1'b0;
                                age_d[inval_set_i][w]   = '0;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                if (access_valid_i || inval_valid_i) begin
                    err_d = 1'b1;
                end
                valid_d[cnt_q] = '0;
                for (int unsigned w = 0; w < N_WAYS; w++) begin
                    age_d[cnt_q][w] = '0;
                end
                cnt_d = cnt_q + SET_BITS'(1);
                if (cnt_q == SET_BITS'(N_SETS - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-first view of the lookup set.
    always_comb begin
        empty_d    = ~valid_d[lookup_set_i];
        age_flat_d = '0;
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            age_flat_d[w*AGE_W +: AGE_W] = age_d[lookup_set_i][w];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            line_empty_q   <= '1;
            line_age_q     <= '0;
            flush_busy_q   <= 1'b0;
            flush_done_q   <= 1'b0;
            protocol_err_q <= 1'b0;
            for (int unsigned s = 0; s < N_SETS; s++) begin
                valid_q[s] <= '0;
                for (int unsigned w = 0; w < N_WAYS; w++) begin
                    age_q[s][w] <= '0;
                end
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            valid_q        <= valid_d;
            age_q          <= age_d;
            line_empty_q   <= empty_d;
            line_age_q     <= age_flat_d;
            flush_busy_q   <= (state_d == FLUSH);
            flush_done_q   <= done_d;
            protocol_err_q <= err_d;
        end
    end

    assign line_empty_o   = line_empty_q;
    assign line_age_o     = line_age_q;
    assign flush_busy_o   = flush_busy_q;
    assign flush_done_o   = flush_done_q;
    assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_way_age_tracker.sv
// Scoreboard bench for way_age_tracker: a reference model queues the expected outputs of every edge,
// a monitor compares them, and directed checks cover the hand-computed test points.
module tb_way_age_tracker;

    logic        clk;
    logic        rst;
    logic        access_valid, access_fill, inval_valid, flush_req;
    logic [1:0]  access_set, inval_set, lookup_set;
    logic [3:0]  access_way, inval_way;
    logic [1:0]  line_empty;
    logic [63:0] line_age;
    logic        flush_busy, flush_done, protocol_err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [1:0]  empty;
        logic [63:0] age;
        logic        busy;
        logic        done;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic        m_valid [4][2];
    logic [31:0] m_age   [4][2];
    logic        m_flush;
    int          m_cnt;

    way_age_tracker dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .access_valid_i (access_valid),
        .access_fill_i  (access_fill),
        .access_set_i   (access_set),
        .access_way_i   (access_way),
        .inval_valid_i  (inval_valid),
        .inval_set_i    (inval_set),
        .inval_way_i    (inval_way),
        .lookup_set_i   (lookup_set),
        .flush_req_i    (flush_req),
        .line_empty_o   (line_empty),
        .line_age_o     (line_age),
        .flush_busy_o   (flush_busy),
        .flush_done_o   (flush_done),
        .protocol_err_o (protocol_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the currently driven inputs and queue the expected outputs.
    task automatic model_edge();
        exp_t e;
        logic err, done;
        err  = 1'b0;
        done = 1'b0;
        if (rst) begin
            for (int s = 0; s < 4; s++)
                for (int w = 0; w < 2; w++) begin
                    m_valid[s][w] = 1'b0;
                    m_age[s][w]   = 32'd0;
                end
            m_flush = 1'b0;
            m_cnt   = 0;
        end else if (m_flush) begin
            if (access_valid || inval_valid) err = 1'b1;
            for (int w = 0; w < 2; w++) begin
                m_valid[m_cnt][w] = 1'b0;
                m_age[m_cnt][w]   = 32'd0;
            end
            if (m_cnt == 3) begin
                m_flush = 1'b0;
                done    = 1'b1;
            end
            m_cnt++;
        end else begin
            if (access_valid) begin
                if (access_way >= 4'd2) err = 1'b1;
                else if (!access_fill && !m_valid[access_set][access_way[0]]) err = 1'b1;
                else begin
                    for (int w = 0; w < 2; w++)
                        if (w != int'(access_way) && m_valid[access_set][w] && m_age[access_set][w] != 32'hFFFF_FFFF)
                            m_age[access_set][w] = m_age[access_set][w] + 32'd1;
                    m_valid[access_set][access_way[0]] = 1'b1;
                    m_age[access_set][access_way[0]]   = 32'd0;
                end
            end
            if (inval_valid) begin
                if (inval_way >= 4'd2) err = 1'b1;
                else begin
                    m_valid[inval_set][inval_way[0]] = 1'b0;
                    m_age[inval_set][inval_way[0]]   = 32'd0;
                end
            end
            if (flush_req) begin
                m_flush = 1'b1;
                m_cnt   = 0;
            end
        end
        e.empty = {~m_valid[lookup_set][1], ~m_valid[lookup_set][0]};
        e.age   = {m_age[lookup_set][1], m_age[lookup_set][0]};
        e.busy  = m_flush;
        e.done  = done;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        access_valid = 1'b0; access_fill = 1'b0; access_set = 2'd0; access_way = 4'd0;
        inval_valid  = 1'b0; inval_set   = 2'd0; inval_way  = 4'd0;
        flush_req    = 1'b0;
    endtask

    task automatic do_access(input logic [1:0] s, input logic [3:0] w, input logic fill);
        idle_inputs();
        access_valid = 1'b1; access_set = s; access_way = w; access_fill = fill;
        step();
    endtask

    task automatic do_idle();
        idle_inputs();
        step();
    endtask

    task automatic read_all_empty(input string tag);
        for (int s = 0; s < 4; s++) begin
            lookup_set = 2'(s);
            do_idle();
            check_eq({tag, "_empty"}, 64'(line_empty), 64'h3);
            check_eq({tag, "_age"}, line_age, 64'h0);
        end
    endtask

    // Monitor: compare every edge against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb_empty", 64'(line_empty), 64'(e.empty));
            check_eq("sb_age", line_age, e.age);
            check_eq("sb_busy", 64'(flush_busy), 64'(e.busy));
            check_eq("sb_done", 64'(flush_done), 64'(e.done));
            check_eq("sb_err", 64'(protocol_err), 64'(e.err));
        end
    end

    initial begin
        int busy_cnt, done_cnt;
        idle_inputs();
        lookup_set = 2'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_pulses", {61'd0, flush_busy, flush_done, protocol_err}, 64'h0);
        read_all_empty("reset");

        // Fill and age in set 1
        lookup_set = 2'd1;
        do_access(2'd1, 4'd0, 1'b1);
        repeat (3) do_access(2'd1, 4'd0, 1'b0);
        check_eq("fill_empty", 64'(line_empty), 64'h2);
        check_eq("fill_age", line_age, 64'h0);
        do_access(2'd1, 4'd1, 1'b1);
        repeat (2) do_access(2'd1, 4'd1, 1'b0);
        check_eq("age_31", line_age, {32'd0, 32'd3});
        check_eq("age_31_empty", 64'(line_empty), 64'h0);

        // Hit to empty way, then out-of-range way
        lookup_set = 2'd2;
        do_access(2'd2, 4'd1, 1'b0);
        check_eq("hit_empty_err", 64'(protocol_err), 64'h1);
        check_eq("hit_empty_set", 64'(line_empty), 64'h3);
        do_idle();
        check_eq("err_one_cycle", 64'(protocol_err), 64'h0);
        do_access(2'd2, 4'd2, 1'b1);
        check_eq("bad_way_err", 64'(protocol_err), 64'h1);
        check_eq("bad_way_set", 64'(line_empty), 64'h3);

        // Simultaneous access and invalidate in set 0
        lookup_set = 2'd0;
        do_access(2'd0, 4'd1, 1'b1);
        do_access(2'd0, 4'd0, 1'b1);
        repeat (4) do_access(2'd0, 4'd0, 1'b0);
        check_eq("pre_sim_age", line_age, {32'd5, 32'd0});
        idle_inputs();
        access_valid = 1'b1; access_set = 2'd0; access_way = 4'd0;
        inval_valid  = 1'b1; inval_set  = 2'd0; inval_way  = 4'd1;
        step();
        check_eq("sim_diff_empty", 64'(line_empty), 64'h2);
        check_eq("sim_diff_age", line_age, 64'h0);
        do_access(2'd0, 4'd1, 1'b1);
        idle_inputs();
        access_valid = 1'b1; access_set = 2'd0; access_way = 4'd0;
        inval_valid  = 1'b1; inval_set  = 2'd0; inval_way  = 4'd0;
        step();
        check_eq("sim_same_empty", 64'(line_empty), 64'h1);
        check_eq("sim_same_age", line_age, {32'd1, 32'd0});

        // Full flush with a dropped fill and an ignored second request
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++)
                do_access(2'(s), 4'(w), 1'b1);
        idle_inputs();
        flush_req = 1'b1;
        step();
        check_eq("flush_busy_start", 64'(flush_busy), 64'h1);
        busy_cnt = 1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            if (i == 0) begin
                access_valid = 1'b1; access_fill = 1'b1; access_set = 2'd3; access_way = 4'd0;
            end
            if (i == 1) flush_req = 1'b1;
            step();
            if (i == 0) check_eq("flush_drop_err", 64'(protocol_err), 64'h1);
            if (flush_busy) busy_cnt++;
            if (flush_done) done_cnt++;
        end
        check_eq("flush_busy_cycles", 64'(busy_cnt), 64'd4);
        check_eq("flush_done_pulses", 64'(done_cnt), 64'd1);
        read_all_empty("flush");

        // Reset in the second flush cycle
        do_access(2'd3, 4'd1, 1'b1);
        do_access(2'd2, 4'd0, 1'b1);
        idle_inputs();
        flush_req = 1'b1;
        step();
        do_idle();
        rst = 1'b1;
        do_idle();
        rst = 1'b0;
        check_eq("rst_flush_busy", 64'(flush_busy), 64'h0);
        check_eq("rst_flush_done", 64'(flush_done), 64'h0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            do_idle();
            if (flush_done || flush_busy) done_cnt++;
        end
        check_eq("rst_flush_quiet", 64'(done_cnt), 64'd0);
        read_all_empty("rst_flush");

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
